// File: rtl/noc_axi4_bridge_pkg.sv
// rtl/noc_axi4_bridge_pkg.sv - shared constants and types for the NoC/AXI4 bridge
package noc_axi4_bridge_pkg;

  localparam int ORD_FWD = 0;
  localparam int ORD_REV = 1;
  localparam int ORD_HDR = 2;

  localparam int LEN_LSB_DEF = 22;
  localparam int LEN_W_DEF   = 8;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } asm_state_e;

endpackage

// File: rtl/noc_axi4_deser_slotq.sv
// rtl/noc_axi4_deser_slotq.sv - packet slot storage with write/read pointers and occupancy
module noc_axi4_deser_slotq
  import noc_axi4_bridge_pkg::*;
#(
  parameter int NOC_W     = 64,
  parameter int HDR_FLITS = 3,
  parameter int P         = 8,
  parameter int CNT_W     = 4,
  parameter int HIDX_W    = 2,
  parameter int WIDX_W    = 3,
  parameter int DEPTH     = 2,
  parameter int OCC_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NOC_W-1:0]             flit,
  input  logic                         clr,
  input  logic                         hdr_we,
  input  logic [HIDX_W-1:0]            hdr_idx,
  input  logic                         pay_we,
  input  logic [WIDX_W-1:0]            pay_idx,
  input  logic                         push,
  input  logic [CNT_W-1:0]             push_cnt,
  input  logic                         push_err,
  input  logic                         pop,
  output logic [HDR_FLITS*NOC_W-1:0]   hdr_out,
  output logic [P*NOC_W-1:0]           data_out,
  output logic [CNT_W-1:0]             cnt_out,
  output logic                         err_out,
  output logic [OCC_W-1:0]             occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [HDR_FLITS-1:0][NOC_W-1:0] hdr_mem [DEPTH];
  logic [P-1:0][NOC_W-1:0]         data_mem [DEPTH];
  logic [CNT_W-1:0]                cnt_mem [DEPTH];
  logic                            err_mem [DEPTH];
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;

  // The slot under assembly is wiped on flit 0 so short packets read back zero headers.
  always_ff @(posedge clk) begin
    if (clr) begin
      hdr_mem[wr_ptr]  <= '0;
      data_mem[wr_ptr] <= '0;
    end
    if (hdr_we) hdr_mem[wr_ptr][hdr_idx] <= flit;
    if (pay_we) data_mem[wr_ptr][pay_idx] <= flit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_mem[i] <= '0;
        err_mem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        cnt_mem[wr_ptr] <= push_cnt;
        err_mem[wr_ptr] <= push_err;
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  assign hdr_out  = hdr_mem[rd_ptr];
  assign data_out = data_mem[rd_ptr];
  assign cnt_out  = cnt_mem[rd_ptr];
  assign err_out  = err_mem[rd_ptr];

endmodule

// File: rtl/noc_axi4_deser_pipe.sv
// rtl/noc_axi4_deser_pipe.sv - NoC packet to wide AXI beat deserializer with slot queue
module noc_axi4_deser_pipe
  import noc_axi4_bridge_pkg::*;
#(
  parameter int NOC_W      = 64,
  parameter int AXI_W      = 512,
  parameter int HDR_FLITS  = 3,
  parameter int LEN_LSB    = LEN_LSB_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int DEPTH      = 2,
  parameter int ORDER_MODE = ORD_HDR,
  parameter int ORDER_BIT  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NOC_W-1:0]                   flit_in,
  input  logic                               flit_in_val,
  output logic                               flit_in_rdy,
  input  logic                               phy_init_done,
  output logic [HDR_FLITS*NOC_W-1:0]         header_out,
  output logic [AXI_W-1:0]                   data_out,
  output logic [$clog2(AXI_W/NOC_W+1)-1:0]   payload_flits_out,
  output logic                               err_out,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

  localparam int P       = AXI_W / NOC_W;
  localparam int CNT_W   = $clog2(P + 1);
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int HIDX_W  = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int WIDX_W  = (P > 1) ? $clog2(P) : 1;
  localparam int OB_FLIT = ORDER_BIT / NOC_W;
  localparam int OB_POS  = ORDER_BIT % NOC_W;

  asm_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_in, rem_q, rem_nx, k_q;
  logic [HIDX_W-1:0] h_q;
  logic [CNT_W-1:0]  n_q, n_first, n_cur;
  logic              err_q, err_first, err_cur, fwd_q, fwd_eff;
  logic              accept, first, done, hdr_we, pay_we, pop;
  logic [WIDX_W-1:0] pay_idx;

  assign flit_in_rdy = rst_n & phy_init_done & (int'(occupancy) < DEPTH);
  assign accept      = flit_in_val & flit_in_rdy;
  assign out_val     = (occupancy != '0);
  assign pop         = out_val & out_rdy;
  assign len_in      = flit_in[LEN_LSB +: LEN_W];
  assign fwd_eff     = (ORDER_MODE == ORD_FWD) ? 1'b1 :
                       (ORDER_MODE == ORD_REV) ? 1'b0 : fwd_q;

  // Payload word count and error flag are fully known from the length field of flit 0.
  always_comb begin
    n_first   = '0;
    err_first = 1'b0;
    if (int'(len_in) < HDR_FLITS - 1) begin
      err_first = 1'b1;
    end else if (int'(len_in) + 1 - HDR_FLITS > P) begin
      n_first   = CNT_W'(P);
      err_first = 1'b1;
    end else begin
      n_first = CNT_W'(int'(len_in) + 1 - HDR_FLITS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    first   = (state_q == ST_HDR) && (h_q == '0);
    rem_nx  = first ? len_in : rem_q - 1'b1;
    done    = accept && (rem_nx == '0);
    n_cur   = first ? n_first : n_q;
    err_cur = first ? err_first : err_q;
    hdr_we  = accept && (state_q == ST_HDR);
    pay_we  = accept && (state_q == ST_DATA) && (int'(k_q) < int'(n_q));
    pay_idx = fwd_eff ? WIDX_W'(k_q) : WIDX_W'(int'(n_q) - 1 - int'(k_q));
    if (accept) begin
      if (done)                                                    state_d = ST_HDR;
      else if (state_q == ST_HDR && int'(h_q) == HDR_FLITS - 1)    state_d = ST_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      k_q   <= '0;
      h_q   <= '0;
      n_q   <= '0;
      err_q <= 1'b0;
      fwd_q <= 1'b1;
    end else if (accept) begin
      rem_q <= rem_nx;
      if (first) begin
        n_q   <= n_first;
        err_q <= err_first;
      end
      if (state_q == ST_HDR && int'(h_q) == OB_FLIT) fwd_q <= flit_in[OB_POS];
      if (done) begin
        h_q <= '0;
        k_q <= '0;
      end else if (state_q == ST_HDR) begin
        h_q <= (int'(h_q) == HDR_FLITS - 1) ? '0 : h_q + 1'b1;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  noc_axi4_deser_slotq #(
    .NOC_W     (NOC_W),
    .HDR_FLITS (HDR_FLITS),
    .P         (P),
    .CNT_W     (CNT_W),
    .HIDX_W    (HIDX_W),
    .WIDX_W    (WIDX_W),
    .DEPTH     (DEPTH),
    .OCC_W     (OCC_W)
  ) u_slotq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flit      (flit_in),
    .clr       (accept & first),
    .hdr_we    (hdr_we),
    .hdr_idx   (h_q),
    .pay_we    (pay_we),
    .pay_idx   (pay_idx),
    .push      (done),
    .push_cnt  (n_cur),
    .push_err  (err_cur),
    .pop       (pop),
    .hdr_out   (header_out),
    .data_out  (data_out),
    .cnt_out   (payload_flits_out),
    .err_out   (err_out),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_noc_axi4_deser_pipe.sv
// tb/tb_noc_axi4_deser_pipe.sv - self-checking bench for noc_axi4_deser_pipe
module tb_noc_axi4_deser_pipe;

  localparam int HDR   = 3;
  localparam int P     = 8;
  localparam int DEPTH = 2;

  typedef logic [63:0] flq_t[$];
  typedef struct {
    logic [191:0] hdr;
    logic [511:0] data;
    int           cnt;
    bit           err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  flit_in = '0;
  logic         flit_in_val = 1'b0;
  logic         flit_in_rdy;
  logic         phy_init_done = 1'b0;
  logic [191:0] header_out;
  logic [511:0] data_out;
  logic [3:0]   payload_flits_out;
  logic         err_out;
  logic         out_val;
  logic         out_rdy = 1'b0;
  logic [1:0]   occupancy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  noc_axi4_deser_pipe #(
    .NOC_W(64), .AXI_W(512), .HDR_FLITS(HDR), .LEN_LSB(22), .LEN_W(8),
    .DEPTH(DEPTH), .ORDER_MODE(2), .ORDER_BIT(0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flit_in           (flit_in),
    .flit_in_val       (flit_in_val),
    .flit_in_rdy       (flit_in_rdy),
    .phy_init_done     (phy_init_done),
    .header_out        (header_out),
    .data_out          (data_out),
    .payload_flits_out (payload_flits_out),
    .err_out           (err_out),
    .out_val           (out_val),
    .out_rdy           (out_rdy),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_f0(input int len, input bit fwd, input logic [15:0] tag);
    return 64'hF000_0000_0000_0000 | (64'(tag) << 32) | (64'(len[7:0]) << 22) | 64'(fwd);
  endfunction

  function automatic flq_t mk_pkt(input int len, input bit fwd, input logic [15:0] tag,
                                  input logic [63:0] pbase);
    flq_t q;
    q.push_back(mk_f0(len, fwd, tag));
    for (int i = 1; i <= len; i++) begin
      if (i < HDR) q.push_back(64'h4800_0000_0000_0000 | (64'(tag) << 16) | 64'(i));
      else         q.push_back(pbase + 64'(i - HDR));
    end
    return q;
  endfunction

  // Expected beat straight from the packet: header flits in place, payload placed by order bit.
  function automatic exp_t model_pkt(input flq_t fl);
    exp_t e;
    int   total, pc;
    bit   fwd;
    e.hdr  = '0;
    e.data = '0;
    total  = int'(fl[0][29:22]) + 1;
    for (int i = 0; i < HDR && i < total; i++) e.hdr[i*64 +: 64] = fl[i];
    pc    = (total > HDR) ? total - HDR : 0;
    e.cnt = (pc > P) ? P : pc;
    e.err = (total < HDR) || (pc > P);
    fwd   = fl[0][0];
    for (int k = 0; k < e.cnt; k++) begin
      if (fwd) e.data[k*64 +: 64] = fl[HDR+k];
      else     e.data[(e.cnt-1-k)*64 +: 64] = fl[HDR+k];
    end
    return e;
  endfunction

  task automatic send_flit(input logic [63:0] f, output bit ok);
    int waitc;
    waitc = 0;
    ok = 1'b0;
    flit_in = f;
    flit_in_val = 1'b1;
    while (!ok && waitc < 200) begin
      @(negedge clk);
      ok = flit_in_rdy;
      @(posedge clk);
      #1;
      waitc++;
    end
    flit_in_val = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: flit %0h not accepted within 200 cycles", f);
    end
  endtask

  task automatic send_pkt(input flq_t fl);
    bit   ok;
    exp_t e;
    e = model_pkt(fl);
    for (int i = 0; i < fl.size(); i++) send_flit(fl[i], ok);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int n);
    out_rdy = 1'b1;
    repeat (n) tick();
    out_rdy = 1'b0;
  endtask

  // Every cycle: ready/occupancy against the model queue depth, head slot against the model head.
  always @(negedge clk) begin
    chk("flit_in_rdy", 512'(flit_in_rdy),
        512'(rst_n && phy_init_done && (exp_q.size() < DEPTH)));
    if (rst_n) begin
      chk("occupancy", 512'(occupancy), 512'(exp_q.size()));
      chk("out_val", 512'(out_val), 512'(exp_q.size() != 0));
      if (out_val && exp_q.size() > 0) begin
        chk("header_out", 512'(header_out), 512'(exp_q[0].hdr));
        chk("data_out", data_out, exp_q[0].data);
        chk("payload_flits_out", 512'(payload_flits_out), 512'(exp_q[0].cnt));
        chk("err_out", 512'(err_out), 512'(exp_q[0].err));
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    flq_t q;
    bit   ok;

    rst_n = 1'b0;
    phy_init_done = 1'b1;
    repeat (3) tick();
    chk("reset_out_val", 512'(out_val), 512'(0));
    chk("reset_occupancy", 512'(occupancy), 512'(0));
    chk("reset_err", 512'(err_out), 512'(0));
    chk("reset_cnt", 512'(payload_flits_out), 512'(0));
    chk("reset_rdy", 512'(flit_in_rdy), 512'(0));
    rst_n = 1'b1;
    tick();

    // forward 8-flit payload
    q = mk_pkt(10, 1'b1, 16'h1111, 64'h10);
    send_pkt(q);
    chk("fwd_latency", 512'(out_val), 512'(1));
    chk("fwd_word0", 512'(data_out[63:0]), 512'(64'h10));
    chk("fwd_word7", 512'(data_out[511:448]), 512'(64'h17));
    chk("fwd_cnt", 512'(payload_flits_out), 512'(8));
    chk("fwd_err", 512'(err_out), 512'(0));
    drain(1);

    // per-packet order: forward then reverse
    q = mk_pkt(4, 1'b1, 16'h2222, 64'hA0);
    send_pkt(q);
    q = mk_pkt(4, 1'b0, 16'h3333, 64'hB0);
    send_pkt(q);
    chk("ord_occ", 512'(occupancy), 512'(2));
    chk("ord_fwd_words", 512'(data_out[127:0]), 512'({64'hA1, 64'hA0}));
    drain(1);
    chk("ord_rev_words", 512'(data_out[127:0]), 512'({64'hB0, 64'hB1}));
    chk("ord_rev_upper", 512'(data_out[511:128]), 512'(0));
    drain(1);

    // backpressure with full queue, then resume after one pop
    q = mk_pkt(3, 1'b1, 16'h4444, 64'hC0);
    send_pkt(q);
    q = mk_pkt(3, 1'b1, 16'h5555, 64'hC1);
    send_pkt(q);
    chk("bp_full_rdy", 512'(flit_in_rdy), 512'(0));
    chk("bp_full_occ", 512'(occupancy), 512'(2));
    q = mk_pkt(3, 1'b0, 16'h6666, 64'hC2);
    fork
      send_pkt(q);
      begin
        repeat (3) tick();
        chk("bp_stall_rdy", 512'(flit_in_rdy), 512'(0));
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("bp_resume_rdy", 512'(flit_in_rdy), 512'(1));
      end
    join
    chk("bp_occ_after", 512'(occupancy), 512'(2));
    drain(2);
    chk("bp_drained", 512'(occupancy), 512'(0));

    // header-only and short packets
    q = mk_pkt(2, 1'b1, 16'h7777, 64'h0);
    send_pkt(q);
    q = mk_pkt(0, 1'b1, 16'h8888, 64'h0);
    send_pkt(q);
    chk("hdronly_cnt", 512'(payload_flits_out), 512'(0));
    chk("hdronly_err", 512'(err_out), 512'(0));
    drain(1);
    chk("short_err", 512'(err_out), 512'(1));
    chk("short_cnt", 512'(payload_flits_out), 512'(0));
    chk("short_hdr0", 512'(header_out[63:0]), 512'(64'hF000_8888_0000_0001));
    chk("short_hdr12", 512'(header_out[191:64]), 512'(0));
    drain(1);

    // overlong packet followed by a normal one
    q = mk_pkt(12, 1'b1, 16'h9999, 64'h100);
    send_pkt(q);
    q = mk_pkt(5, 1'b1, 16'hAAAA, 64'h200);
    send_pkt(q);
    chk("long_err", 512'(err_out), 512'(1));
    chk("long_cnt", 512'(payload_flits_out), 512'(8));
    chk("long_word0", 512'(data_out[63:0]), 512'(64'h100));
    chk("long_word7", 512'(data_out[511:448]), 512'(64'h107));
    drain(2);

    // reset mid-payload with one slot full
    q = mk_pkt(3, 1'b1, 16'hBBBB, 64'h280);
    send_pkt(q);
    q = mk_pkt(10, 1'b1, 16'hCCCC, 64'h290);
    for (int i = 0; i < 5; i++) send_flit(q[i], ok);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_occ", 512'(occupancy), 512'(0));
    chk("rst_out_val", 512'(out_val), 512'(0));
    q = mk_pkt(4, 1'b1, 16'hDDDD, 64'h300);
    send_pkt(q);
    chk("rst_clean_words", 512'(data_out[127:0]), 512'({64'h301, 64'h300}));
    chk("rst_clean_upper", 512'(data_out[511:128]), 512'(0));
    chk("rst_clean_err", 512'(err_out), 512'(0));
    drain(1);

    // phy gating
    phy_init_done = 1'b0;
    tick();
    chk("phy_gate_rdy", 512'(flit_in_rdy), 512'(0));
    flit_in = mk_f0(0, 1'b1, 16'hEEEE);
    flit_in_val = 1'b1;
    repeat (2) tick();
    chk("phy_gate_occ", 512'(occupancy), 512'(0));
    flit_in_val = 1'b0;
    phy_init_done = 1'b1;
    repeat (3) tick();
    chk("final_occ", 512'(occupancy), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
